// File: rtl/data_memory_arbiter_pkg.sv
// rtl/data_memory_arbiter_pkg.sv - shared state encoding and default limits for the data memory arbiter
package data_memory_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  localparam int MAX_WAIT_DEF  = 4;
  localparam int BURST_MAX_DEF = 8;

endpackage

// File: rtl/data_memory_arbiter.sv
// rtl/data_memory_arbiter.sv - two-port arbiter for the single-port data memory (MEM stage vs loader)
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MAX_WAIT  = MAX_WAIT_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Req0,
  input  logic              Write0,
  input  logic [31:0]       Addr0,
  input  logic [DATA_W-1:0] WData0,
  output logic              Gnt0,
  output logic              Stall0,
  input  logic              Req1,
  input  logic              Write1,
  input  logic              Lock1,
  input  logic [31:0]       Addr1,
  input  logic [DATA_W-1:0] WData1,
  output logic              Gnt1,
  output logic [DATA_W-1:0] RData,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [DATA_W-1:0] MemReadData,
  output logic [15:0]       ConflictCnt
);

  localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
  localparam int BURST_W = $clog2(BURST_MAX + 1);

  arb_state_e         state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [15:0]        conflict_q, conflict_d;
  logic               override1;
  logic               gnt0, gnt1;

  // Only the low ADDR_W address bits reach the memory; the rest wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{Addr0[31:ADDR_W], Addr1[31:ADDR_W]};

  // Grant decision: port 0 wins unless a burst holds the memory or port 1 has starved long enough.
  always_comb begin
    override1 = Req1 && (wait_q == WAIT_W'(MAX_WAIT));
    gnt0      = Rst_n && Req0 && (state_q != ARB_BURST) && !override1;
    gnt1      = Rst_n && Req1 && !gnt0;
  end

  assign Gnt0        = gnt0;
  assign Gnt1        = gnt1;
  assign Stall0      = Req0 && !gnt0;
  assign RData       = MemReadData;
  assign ConflictCnt = conflict_q;

  // Memory-side mux: route the granted port, drive all zeros when idle.
  always_comb begin
    MemAddr  = '0;
    MemWData = '0;
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    if (gnt0) begin
      MemAddr  = Addr0[ADDR_W-1:0];
      MemWData = WData0;
      MemWrite = Write0;
      MemRead  = !Write0;
    end else if (gnt1) begin
      MemAddr  = Addr1[ADDR_W-1:0];
      MemWData = WData1;
      MemWrite = Write1;
      MemRead  = !Write1;
    end
  end

  // Next-state: starvation counter, burst tracking and conflict statistics.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    burst_d    = burst_q;
    conflict_d = conflict_q;

    if (gnt1 || !Req1) begin
      wait_d = '0;
    end else if (wait_q != WAIT_W'(MAX_WAIT)) begin
      wait_d = wait_q + 1'b1;
    end

    if (Req0 && Req1 && (conflict_q != 16'hFFFF)) begin
      conflict_d = conflict_q + 16'd1;
    end

    case (state_q)
      ARB_IDLE: begin
        // The entry grant is the first cycle of the burst.
        if (gnt1 && Lock1) begin
          state_d = ARB_BURST;
          burst_d = BURST_W'(1);
        end
      end
      ARB_BURST: begin
        // burst_d is the number of port-1 cycles granted once this cycle completes.
        burst_d = burst_q + 1'b1;
        if (!Req1 || !Lock1 || (burst_d == BURST_W'(BURST_MAX))) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset; reset aborts any burst.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q    <= ARB_IDLE;
      wait_q     <= '0;
      burst_q    <= '0;
      conflict_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      burst_q    <= burst_d;
      conflict_q <= conflict_d;
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb/tb_data_memory_arbiter.sv - self-checking bench for data_memory_arbiter with a behavioural memory
module tb_data_memory_arbiter;

  localparam int MAX_WAIT  = 4;
  localparam int BURST_MAX = 8;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Req0, Write0, Req1, Write1, Lock1;
  logic [31:0] Addr0, WData0, Addr1, WData1;
  logic        Gnt0, Stall0, Gnt1, MemWrite, MemRead;
  logic [31:0] RData, MemWData, MemReadData;
  logic [9:0]  MemAddr;
  logic [15:0] ConflictCnt;

  always #5 Clk = ~Clk;

  // data memory behind the arbiter
  logic [31:0] mem [1024];
  always @(posedge Clk) if (MemWrite) mem[MemAddr] <= MemWData;
  assign MemReadData = mem[MemAddr];

  data_memory_arbiter dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .Req0(Req0), .Write0(Write0), .Addr0(Addr0), .WData0(WData0),
    .Gnt0(Gnt0), .Stall0(Stall0),
    .Req1(Req1), .Write1(Write1), .Lock1(Lock1), .Addr1(Addr1), .WData1(WData1),
    .Gnt1(Gnt1), .RData(RData),
    .MemAddr(MemAddr), .MemWData(MemWData), .MemWrite(MemWrite), .MemRead(MemRead),
    .MemReadData(MemReadData), .ConflictCnt(ConflictCnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: who has been waiting how long, whether a burst is running and how many cycles it used
  bit          m_burst = 0;
  int          m_bgr = 0;
  int          m_den = 0;
  int          m_conf = 0;
  logic [31:0] mm [1024];

  logic        o_g0, o_g1, o_stall;
  logic [31:0] o_rdata;
  logic [9:0]  o_addr;

  task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic l1, input logic [31:0] a1,
                       input logic [31:0] d1);
    Req0 = r0; Write0 = w0; Addr0 = a0; WData0 = d0;
    Req1 = r1; Write1 = w1; Lock1 = l1; Addr1 = a1; WData1 = d1;
  endtask

  task automatic step();
    logic       e_g0, e_g1, ewr, erd;
    logic [9:0] ea;
    logic [31:0] ewd;
    @(negedge Clk);
    e_g0 = Rst_n && Req0 && !m_burst && !(Req1 && m_den >= MAX_WAIT);
    e_g1 = Rst_n && Req1 && !e_g0;
    ea = '0; ewd = '0; ewr = 1'b0; erd = 1'b0;
    if (e_g0) begin
      ea = Addr0[9:0]; ewd = WData0; ewr = Write0; erd = !Write0;
    end else if (e_g1) begin
      ea = Addr1[9:0]; ewd = WData1; ewr = Write1; erd = !Write1;
    end
    chk("Gnt0", Gnt0, e_g0);
    chk("Gnt1", Gnt1, e_g1);
    chk("Stall0", Stall0, Req0 && !e_g0);
    chk("MemWrite", MemWrite, ewr);
    chk("MemRead", MemRead, erd);
    chk("MemAddr", MemAddr, ea);
    chk("MemWData", MemWData, ewd);
    chk("ConflictCnt", ConflictCnt, m_conf);
    if (erd) chk("RData", RData, mm[ea]);
    o_g0 = Gnt0; o_g1 = Gnt1; o_stall = Stall0; o_rdata = RData; o_addr = MemAddr;
    @(posedge Clk);
    if (!Rst_n) begin
      m_burst = 0; m_bgr = 0; m_den = 0; m_conf = 0;
    end else begin
      if (ewr) mm[ea] = ewd;
      if (Req0 && Req1 && m_conf < 65535) m_conf++;
      if (Req1 && !e_g1) m_den = (m_den < MAX_WAIT) ? m_den + 1 : m_den;
      else m_den = 0;
      if (!m_burst) begin
        if (e_g1 && Lock1) begin m_burst = 1; m_bgr = 1; end
      end else begin
        if (e_g1) m_bgr++;
        if (!Req1 || !Lock1 || m_bgr >= BURST_MAX) m_burst = 0;
      end
    end
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
  endtask

  logic h0 [64];
  logic h1 [64];
  logic [31:0] a1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] <= 32'h0;
      mm[i] = 32'h0;
    end
    mem[1023] <= 32'h0000_1234;
    mm[1023] = 32'h0000_1234;

    // reset with both ports requesting
    Rst_n = 1'b0;
    drive(1, 1, 3, 32'h33, 1, 1, 1, 4, 32'h44);
    step();
    step();
    chk("rst_gnt0", o_g0, 1'b0);
    chk("rst_gnt1", o_g1, 1'b0);
    chk("rst_stall0", o_stall, 1'b1);
    chk("rst_conflict", ConflictCnt, 16'd0);
    Rst_n = 1'b1;

    // 1: port 0 write then read back
    drive(1, 1, 5, 55, 0, 0, 0, 0, 0);
    step();
    chk("t1_gnt0", o_g0, 1'b1);
    chk("t1_stall0", o_stall, 1'b0);
    drive(1, 0, 5, 0, 0, 0, 0, 0, 0);
    step();
    chk("t1_rdata", o_rdata, 32'd55);
    idle();

    // 2: both ports held for six cycles
    drive(1, 0, 7, 0, 1, 0, 0, 8, 0);
    for (int c = 0; c < 6; c++) begin
      step();
      h0[c] = o_g0;
      h1[c] = o_g1;
    end
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("t2_gnt0_c%0d", c + 1), h0[c], (c == 4) ? 1'b0 : 1'b1);
      chk($sformatf("t2_gnt1_c%0d", c + 1), h1[c], (c == 4) ? 1'b1 : 1'b0);
    end
    chk("t2_conflict", ConflictCnt, 16'd6);
    idle();

    // 3: locked loader burst to 10..19 against a busy MEM stage
    a1 = 10;
    for (int k = 0; k < 64; k++) begin
      h0[k] = 1'b0;
      h1[k] = 1'b0;
    end
    for (int k = 0; k < 60 && a1 < 20; k++) begin
      drive(1, 0, 0, 0, 1, 1, 1, a1, 32'h100 + a1);
      step();
      h0[k] = o_g0;
      h1[k] = o_g1;
      if (o_g1) a1++;
    end
    chk("t3_done", a1, 32'd20);
    for (int k = 0; k < 4; k++) chk($sformatf("t3_pre_gnt0_%0d", k), h0[k], 1'b1);
    for (int k = 4; k < 12; k++) chk($sformatf("t3_burst_gnt1_%0d", k), h1[k], 1'b1);
    for (int k = 12; k < 16; k++) chk($sformatf("t3_post_gnt0_%0d", k), h0[k], 1'b1);
    chk("t3_resume_gnt1", h1[16], 1'b1);
    idle();
    chk("t3_mem17", mem[17], 32'h111);
    chk("t3_mem19", mem[19], 32'h113);

    // 4: reset in the third cycle of a burst
    drive(0, 0, 0, 0, 1, 1, 1, 30, 32'hAA);
    step();
    drive(0, 0, 0, 0, 1, 1, 1, 31, 32'hAB);
    step();
    Rst_n = 1'b0;
    drive(0, 0, 0, 0, 1, 1, 1, 32, 32'hAC);
    step();
    chk("t4_rst_gnt1", o_g1, 1'b0);
    Rst_n = 1'b1;
    drive(1, 0, 30, 0, 1, 1, 1, 32, 32'hAC);
    step();
    chk("t4_release_gnt0", o_g0, 1'b1);
    chk("t4_release_rdata", o_rdata, 32'hAA);
    idle();
    chk("t4_mem31", mem[31], 32'hAB);
    chk("t4_mem32", mem[32], 32'h0);

    // 5: address wrap to word 1023
    drive(0, 0, 0, 0, 1, 0, 0, 32'h7FF, 0);
    step();
    chk("t5_addr", o_addr, 10'h3FF);
    chk("t5_rdata_init", o_rdata, 32'h1234);
    drive(0, 0, 0, 0, 1, 1, 0, 32'hC000_03FF, -32'sd20);
    step();
    drive(0, 0, 0, 0, 1, 0, 0, 32'h7FF, 0);
    step();
    chk("t5_rdata_neg", o_rdata, 32'hFFFF_FFEC);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
